keypad_scanner: RTL

- Matrix-keypad reader for the toy controller. It is the input-side counterpart of the multiplexed 7-segment display driver.
- The display strobes digit lines and writes segments. This block strobes column lines and reads row lines of a 4x4 active-low keypad.
- It debounces across whole scan frames and delivers one decoded key event per accepted press. Downstream mode/speed logic consumes the events.

---
 rtl/keypad_scanner_pkg.sv | 21 ++
 rtl/kp_col_strobe.sv | 57 +++++
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// rtl/keypad_scanner_pkg.sv - shared types and constants for the keypad scanner
package keypad_scanner_pkg;

    localparam int unsigned KP_ROWS = 4;
    localparam int unsigned KP_COLS = 4;
    localparam int unsigned KEY_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DEB,
        ST_HELD,
        ST_REL_DEB
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_ONE,
        FR_MULTI
    } frame_res_e;

endpackage

// File: rtl/kp_col_strobe.sv
// rtl/kp_col_strobe.sv - column strobe generator: dwell counter and column index
module kp_col_strobe
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    output logic [KP_COLS-1:0]          col_o,
    output logic [$clog2(KP_COLS)-1:0]  col_idx_o,
    output logic                        sample_o,
    output logic                        last_col_o
);

    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(KP_COLS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic          run_q,   run_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] col_q,   col_d;

    // run_q lags the enable by one cycle so a park or restart lands on a clean column 0
    always_comb begin
        run_d   = en_i;
        dwell_d = dwell_q;
        col_d   = col_q;
        if (!en_i || !run_q) begin
            dwell_d = '0;
            col_d   = '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            col_d   = col_q + CW'(1);
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q   <= 1'b0;
            dwell_q <= '0;
            col_q   <= '0;
        end else begin
            run_q   <= run_d;
            dwell_q <= dwell_d;
            col_q   <= col_d;
        end
    end

    assign col_o      = run_q ? ~(KP_COLS'(1) << col_q) : '1;
    assign col_idx_o  = col_q;
    assign sample_o   = run_q && (dwell_q == DWELL_LAST);
    assign last_col_o = (col_q == CW'(KP_COLS - 1));

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 active-low keypad scanner with frame debounce
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned DEBOUNCE_SCANS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               on_off,
    input  logic [KP_ROWS-1:0] row_in,
    output logic [KP_COLS-1:0] col_out,
    output logic [KEY_W-1:0]   key_code,
    output logic               key_valid,
    output logic               key_held,
    output logic               multi_key
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic [KP_ROWS-1:0] sync1_q, sync2_q;
    logic [1:0]         col_idx;
    logic               sample, last_col;

    logic [1:0]       acc_cnt_q, acc_cnt_d;
    logic [KEY_W-1:0] acc_code_q, acc_code_d;
    kp_state_e        state_q, state_d;
    logic [3:0]       deb_q, deb_d;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             multi_q, multi_d;

    logic [1:0]       col_cnt, row_first, tot_cnt;
    logic [KEY_W-1:0] tot_code;
    frame_res_e       frame_res;
    logic             frame_evt, accept;
    logic [KEY_W-1:0] accept_code;

    kp_col_strobe #(.SCAN_DIV(SCAN_DIV)) u_strobe (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (on_off),
        .col_o      (col_out),
        .col_idx_o  (col_idx),
        .sample_o   (sample),
        .last_col_o (last_col)
    );

    // Per-column contribution merged into the running frame tally; lowest row wins
    always_comb begin
        col_cnt   = 2'd0;
        row_first = 2'd0;
        for (int r = KP_ROWS - 1; r >= 0; r--) begin
            if (!sync2_q[r]) row_first = 2'(r);
        end
        for (int r = 0; r < KP_ROWS; r++) begin
            if (!sync2_q[r] && col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
        end
        tot_cnt  = ({1'b0, acc_cnt_q} + {1'b0, col_cnt} >= 3'd2) ? 2'd2 : acc_cnt_q + col_cnt;
        tot_code = (acc_cnt_q == 2'd0) ? {row_first, col_idx} : acc_code_q;
        frame_res = (tot_cnt == 2'd0) ? FR_NONE : (tot_cnt == 2'd1) ? FR_ONE : FR_MULTI;
        frame_evt = sample && last_col;
    end

    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        acc_code_d  = acc_code_q;
        state_d     = state_q;
        deb_d       = deb_q;
        cand_d      = cand_q;
        code_d      = code_q;
        valid_d     = 1'b0;
        held_d      = held_q;
        multi_d     = 1'b0;
        accept      = 1'b0;
        accept_code = cand_q;
        if (!on_off) begin
            acc_cnt_d  = 2'd0;
            acc_code_d = '0;
            state_d    = ST_IDLE;
            deb_d      = 4'd0;
            held_d     = 1'b0;
        end else if (sample) begin
            acc_cnt_d  = last_col ? 2'd0 : tot_cnt;
            acc_code_d = last_col ? '0   : tot_code;
        end
        if (on_off && frame_evt) begin
            multi_d = (frame_res == FR_MULTI);
            case (state_q)
                ST_IDLE: begin
                    if (frame_res == FR_ONE) begin
                        cand_d = tot_code;
                        deb_d  = 4'd1;
                        if (DEB_N == 4'd1) begin
                            accept      = 1'b1;
                            accept_code = tot_code;
                        end else begin
                            state_d = ST_PRESS_DEB;
                        end
                    end
                end
                ST_PRESS_DEB: begin
                    if (frame_res == FR_ONE && tot_code == cand_q) begin
                        deb_d = deb_q + 4'd1;
                        if (deb_q + 4'd1 >= DEB_N) accept = 1'b1;
                    end else if (frame_res == FR_ONE) begin
                        cand_d = tot_code;
                        deb_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        deb_d   = 4'd0;
                    end
                end
                ST_HELD: begin
                    if (frame_res == FR_NONE) begin
                        deb_d   = 4'd1;
                        state_d = ST_REL_DEB;
                        if (DEB_N == 4'd1) begin
                            held_d  = 1'b0;
                            state_d = ST_IDLE;
                            deb_d   = 4'd0;
                        end
                    end
                end
                ST_REL_DEB: begin
                    if (frame_res == FR_NONE) begin
                        deb_d = deb_q + 4'd1;
                        if (deb_q + 4'd1 >= DEB_N) begin
                            held_d  = 1'b0;
                            state_d = ST_IDLE;
                            deb_d   = 4'd0;
                        end
                    end else begin
                        state_d = ST_HELD;
                        deb_d   = 4'd0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (accept) begin
                code_d  = accept_code;
                valid_d = 1'b1;
                held_d  = 1'b1;
                state_d = ST_HELD;
                deb_d   = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            acc_cnt_q  <= 2'd0;
            acc_code_q <= '0;
            state_q    <= ST_IDLE;
            deb_q      <= 4'd0;
            cand_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            sync1_q    <= row_in;
            sync2_q    <= sync1_q;
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            deb_q      <= deb_d;
            cand_q     <= cand_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
            multi_q    <= multi_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;
    assign multi_key = multi_q;

endmodule
